// File: rtl/ones_count_accumulator.sv
// ones_count_accumulator
// Consumes the 2-bit ones-count {y1,y0} from an asynchronous gate-level
// ones-counter. The count is synchronised, filtered for stability and each
// stable value (epoch) is accepted at most once. WINDOW accepted values are
// summed and the total is offered to a consumer.
//
// Handshake: sum/sum_valid form a valid/ack pair. Once sum_valid rises it
// stays high and sum stays constant until the consumer drives ack=1. The
// transfer happens on the rising clock edge where sum_valid=1 and ack=1.
// sum_valid drops on the following cycle. sum keeps its last value after
// the transfer.
module ones_count_accumulator #(
  parameter int WINDOW = 4,
  parameter int SETTLE = 2,
  parameter int OUT_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         y1,
  input  logic                         y0,
  input  logic                         ack,
  output logic [OUT_W-1:0]             sum,
  output logic                         sum_valid,
  output logic                         busy,
  output logic [$clog2(WINDOW+1)-1:0]  n_acc
);

  localparam int NW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // state is the FSM observation point for checkers
  state_t state;
  state_t state_next;

  // Synchroniser stages. s_meta may go metastable; ys is the safe count.
  logic [1:0]       s_meta;
  logic [1:0]       ys;
  // Consecutive cycles in which ys has held its value (saturates at SETTLE).
  logic [SW-1:0]    stab_cnt;
  // Set once the current stable epoch has been counted.
  logic             accepted;
  logic [OUT_W-1:0] acc;

  logic             ys_change;
  logic             stable;
  logic             start_go;
  logic             accept;
  logic             last_accept;
  logic [OUT_W-1:0] ys_ext;
  logic [OUT_W-1:0] acc_plus;

  // s_meta holds the value ys takes at the next edge, so comparing the two
  // is the ys==ys_prev comparison evaluated one cycle earlier; this keeps
  // pin-to-accept latency at 2 + SETTLE cycles.
  assign ys_change   = (s_meta != ys);
  assign stable      = (stab_cnt == SW'(SETTLE));
  assign start_go    = (state == IDLE) && start;
  assign accept      = (state == ACCUM) && stable && !accepted;
  assign last_accept = accept && (n_acc == NW'(WINDOW - 1));
  assign ys_ext      = OUT_W'(ys);
  assign acc_plus    = acc + ys_ext;
  assign busy        = (state != IDLE);

  // Two-flop synchroniser for the asynchronous count inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 2'b00;
      ys     <= 2'b00;
    end else begin
      s_meta <= {y1, y0};
      ys     <= s_meta;
    end
  end

  // Stability counter: restarts on any ys change, saturates at SETTLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (ys_change) begin
      stab_cnt <= '0;
    end else if (!stable) begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // Accepted flag: one count per epoch; a new epoch or a new window re-arms it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accepted <= 1'b0;
    end else if (ys_change || start_go) begin
      accepted <= 1'b0;
    end else if (accept) begin
      accepted <= 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; start is only honoured in IDLE, ack only in DONE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)       state_next = ACCUM;
      ACCUM:   if (last_accept) state_next = DONE;
      DONE:    if (ack)         state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  // Accumulator, sample counter and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      n_acc     <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
    end else begin
      if (start_go) begin
        acc   <= '0;
        n_acc <= '0;
      end else if (accept) begin
        acc   <= acc_plus;
        n_acc <= n_acc + NW'(1);
      end
      if (last_accept) begin
        sum       <= acc_plus;
        sum_valid <= 1'b1;
      end else if ((state == DONE) && ack) begin
        sum_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Bench for ones_count_accumulator: directed scenarios plus randomized
// windows of stable epochs and short glitches, scored against a run-level
// reference model.
module tb_ones_count_accumulator;

  localparam int WINDOW = 4;
  localparam int SETTLE = 2;
  localparam int OUT_W  = 4;
  localparam int NW     = $clog2(WINDOW + 1);
  localparam int LONG   = 99;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic y1    = 1'b0;
  logic y0    = 1'b0;
  logic ack   = 1'b0;
  logic [OUT_W-1:0] sum;
  logic             sum_valid;
  logic             busy;
  logic [NW-1:0]    n_acc;

  always #5 clk = ~clk;

  ones_count_accumulator #(
    .WINDOW(WINDOW),
    .SETTLE(SETTLE),
    .OUT_W (OUT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .y1       (y1),
    .y0       (y0),
    .ack      (ack),
    .sum      (sum),
    .sum_valid(sum_valid),
    .busy     (busy),
    .n_acc    (n_acc)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];
  logic [OUT_W-1:0] exp_v;
  logic             prev_valid = 1'b0;

  // Runs of constant pin value for one window. Run 0 is the value already
  // held when start arrives; the last run is held until the result appears.
  int run_v[$];
  int run_l[$];
  int cur_y = 0;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: every run lasting more than SETTLE cycles is one stable
  // epoch worth its value; the first WINDOW epochs are summed mod 2**OUT_W.
  function automatic logic [OUT_W-1:0] model_sum();
    int n = 0;
    int s = 0;
    for (int i = 0; i < run_v.size(); i++) begin
      if (run_l[i] > SETTLE && n < WINDOW) begin
        s += run_v[i];
        n++;
      end
    end
    return OUT_W'(s % (1 << OUT_W));
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sum_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sum_unexpected: got=%0d expected=none at %0t", sum, $time);
      end else begin
        exp_v = exp_q.pop_front();
        check("sum", int'(sum), int'(exp_v));
      end
    end
    prev_valid = sum_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_y(input int v, input int hold);
    {y1, y0} = v[1:0];
    cur_y = v;
    repeat (hold) tick();
  endtask

  // Issue start and play run_v[1..]; run 0 must already be on the pins.
  // pre_hold > 0 keeps run 0 for that many cycles after start.
  task automatic play_window(input int pre_hold);
    int counted;
    int v;
    int k;
    exp_q.push_back(model_sum());
    counted = (run_l[0] > SETTLE) ? 1 : 0;
    start = 1'b1;
    if (pre_hold > 0) begin
      for (int j = 0; j < pre_hold; j++) begin
        tick();
        start = 1'b0;
      end
      check("pre_hold_n_acc", int'(n_acc), counted);
    end
    for (int i = 1; i < run_v.size(); i++) begin
      v = run_v[i];
      {y1, y0} = v[1:0];
      cur_y = v;
      if (i == run_v.size() - 1) begin
        k = 0;
        while (!sum_valid && k < 80) begin
          tick();
          start = 1'b0;
          k++;
        end
        check("valid_timeout", int'(sum_valid), 1);
        check("n_acc_full", int'(n_acc), WINDOW);
        check("busy_done", int'(busy), 1);
      end else begin
        for (int j = 0; j < run_l[i]; j++) begin
          tick();
          start = 1'b0;
        end
        if (run_l[i] > SETTLE) counted++;
        if (run_l[i] >= SETTLE + 4) check("n_acc_step", int'(n_acc), counted);
      end
    end
  endtask

  task automatic finish_window();
    repeat ($urandom_range(0, 3)) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_valid_low", int'(sum_valid), 0);
    check("ack_busy_low", int'(busy), 0);
    repeat (6) tick();
  endtask

  task automatic gen_random_runs();
    int counted;
    int v;
    int len;
    run_v.delete();
    run_l.delete();
    run_v.push_back(cur_y);
    run_l.push_back(LONG);
    counted = 1;
    while (counted < WINDOW) begin
      v = $urandom_range(0, 3);
      while (v == run_v[run_v.size() - 1]) v = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 30) begin
        len = $urandom_range(1, SETTLE);
      end else begin
        len = $urandom_range(SETTLE + 1, 7);
        counted++;
      end
      run_v.push_back(v);
      run_l.push_back(len);
    end
    run_l[run_l.size() - 1] = LONG;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    // 1. asynchronous reset with random inputs, checked before any edge
    #1;
    rst   = 1'b1;
    start = 1'($urandom_range(0, 1));
    ack   = 1'($urandom_range(0, 1));
    y1    = 1'($urandom_range(0, 1));
    y0    = 1'($urandom_range(0, 1));
    #1;
    check("rst_sum", int'(sum), 0);
    check("rst_valid", int'(sum_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_n_acc", int'(n_acc), 0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    ack   = 1'b0;
    rst   = 1'b0;
    set_y(1, 6);

    // 2. four distinct epochs: 01 already stable, then 10, 11, 00
    run_v = '{1, 2, 3, 0};
    run_l = '{LONG, 6, 6, LONG};
    play_window(0);
    finish_window();

    // 3. one-cycle glitch to 11 inside a 00 stretch
    run_v = '{0, 3, 0, 1, 2};
    run_l = '{LONG, 1, 6, 6, LONG};
    play_window(0);
    finish_window();

    // 4. 11 held 30 cycles after start counts once
    set_y(3, 6);
    run_v = '{3, 2, 1, 3};
    run_l = '{LONG, 6, 6, LONG};
    play_window(30);

    // 5. DONE ignores input activity; ack together with start does not restart
    for (int i = 0; i < 10; i++) begin
      {y1, y0} = 2'($urandom_range(0, 3));
      tick();
    end
    set_y(1, 1);
    check("done_sum_hold", int'(sum), 9);
    check("done_n_acc_hold", int'(n_acc), WINDOW);
    check("done_valid_hold", int'(sum_valid), 1);
    ack   = 1'b1;
    start = 1'b1;
    tick();
    ack   = 1'b0;
    start = 1'b0;
    check("ack_start_valid", int'(sum_valid), 0);
    check("ack_start_busy", int'(busy), 0);
    repeat (3) tick();
    check("no_restart_busy", int'(busy), 0);
    check("sum_kept", int'(sum), 9);

    // 6. reset in the middle of a window, then four separate 11 epochs
    set_y(3, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_y(0, 6);
    check("mid_n_acc", int'(n_acc), 2);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_sum", int'(sum), 0);
    check("midrst_valid", int'(sum_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_n_acc", int'(n_acc), 0);
    tick();
    rst = 1'b0;
    set_y(3, 6);
    run_v = '{3, 0, 3, 0, 3, 0, 3};
    run_l = '{LONG, 1, 6, 1, 6, 1, LONG};
    play_window(0);
    finish_window();

    // randomized windows
    for (int w = 0; w < 20; w++) begin
      gen_random_runs();
      play_window(($urandom_range(0, 3) == 0) ? $urandom_range(SETTLE + 4, 10) : 0);
      finish_window();
    end

    repeat (5) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
